// File: rtl/dlf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlf_pkg
// Description : Shared types and constants for the digital loop filter MAC
//               sequencer: FSM state encoding, default widths and the
//               power-on loop filter coefficient set.
// Revision    : 1.0  initial release
// ============================================================================
package dlf_pkg;

    localparam int COEF_W_DEFAULT = 21;
    localparam int B_W_DEFAULT    = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FF   = 2'd1,
        ST_FB   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Power-on feedforward taps (two's complement, B_W_DEFAULT bits)
    localparam logic [B_W_DEFAULT-1:0] C_B0_RST = 13'h0B66;
    localparam logic [B_W_DEFAULT-1:0] C_B1_RST = 13'h0BD7;
    localparam logic [B_W_DEFAULT-1:0] C_B2_RST = 13'h157A;
    localparam logic [B_W_DEFAULT-1:0] C_B3_RST = 13'h150A;

    // Power-on feedback taps (two's complement, COEF_W_DEFAULT bits)
    localparam logic [COEF_W_DEFAULT-1:0] C_A0_RST = 21'h091DFC;
    localparam logic [COEF_W_DEFAULT-1:0] C_A1_RST = 21'h110794;
    localparam logic [COEF_W_DEFAULT-1:0] C_A2_RST = 21'h066CEC;
    localparam logic [COEF_W_DEFAULT-1:0] C_A3_RST = 21'h1F6D98;

    function automatic logic [B_W_DEFAULT-1:0] b_reset(input logic [1:0] idx);
        case (idx)
            2'd0:    b_reset = C_B0_RST;
            2'd1:    b_reset = C_B1_RST;
            2'd2:    b_reset = C_B2_RST;
            default: b_reset = C_B3_RST;
        endcase
    endfunction

    function automatic logic [COEF_W_DEFAULT-1:0] a_reset(input logic [1:0] idx);
        case (idx)
            2'd0:    a_reset = C_A0_RST;
            2'd1:    a_reset = C_A1_RST;
            2'd2:    a_reset = C_A2_RST;
            default: a_reset = C_A3_RST;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlf_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : dlf_coef_bank
// Description : Shadow/active coefficient register pair. Writes always land
//               in the shadow bank; a pending commit copies shadow to active
//               only while the sequencer is idle, so a running frame always
//               sees one consistent coefficient set.
// Revision    : 1.0  initial release
// ============================================================================
module dlf_coef_bank
    import dlf_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT,
    parameter int B_W    = B_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [COEF_W-1:0] data,
    input  logic              commit_req,
    input  logic              idle,
    input  logic              sel_b,
    input  logic              sel_a,
    input  logic [1:0]        tap,
    output logic              commit_pending,
    output logic [COEF_W-1:0] coef
);

    logic [B_W-1:0]    r_b_shadow [4];
    logic [B_W-1:0]    r_b_active [4];
    logic [COEF_W-1:0] r_a_shadow [4];
    logic [COEF_W-1:0] r_a_active [4];
    logic              r_pending;
    logic              w_do_commit;

    assign w_do_commit    = idle & r_pending;
    assign commit_pending = r_pending;

    // Shadow writes, idle-time commit (forwarding a same-cycle write) and pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_b_shadow[i] <= B_W'(b_reset(2'(i)));
                r_b_active[i] <= B_W'(b_reset(2'(i)));
                r_a_shadow[i] <= COEF_W'(a_reset(2'(i)));
                r_a_active[i] <= COEF_W'(a_reset(2'(i)));
            end
            r_pending <= 1'b0;
        end else begin
            if (we) begin
                if (addr[2]) begin
                    r_a_shadow[addr[1:0]] <= data;
                end else begin
                    r_b_shadow[addr[1:0]] <= data[B_W-1:0];
                end
            end
            if (w_do_commit) begin
                for (int i = 0; i < 4; i++) begin
                    r_b_active[i] <= (we && !addr[2] && (addr[1:0] == 2'(i)))
                                     ? data[B_W-1:0] : r_b_shadow[i];
                    r_a_active[i] <= (we && addr[2] && (addr[1:0] == 2'(i)))
                                     ? data : r_a_shadow[i];
                end
            end
            r_pending <= commit_req | (r_pending & ~w_do_commit);
        end
    end

    // Present the active tap: sign-extended b in feedforward, a in feedback, else zero
    always_comb begin
        coef = '0;
        if (sel_b) begin
            coef = {{(COEF_W-B_W){r_b_active[tap][B_W-1]}}, r_b_active[tap]};
        end else if (sel_a) begin
            coef = r_a_active[tap];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dlf_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dlf_mac_sequencer
// Description : Sequences one loop filter update per accepted sample: four
//               feedforward MAC cycles over x history, four feedback MAC
//               cycles over y history, then one write-back cycle.
// Revision    : 1.0  initial release
// ============================================================================
module dlf_mac_sequencer
    import dlf_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT,
    parameter int B_W    = B_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic              in_data,
    output logic              in_ready,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_commit,
    input  logic              ovr_clr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_src,
    output logic              wb_en,
    output logic [1:0]        tap_idx,
    output logic [COEF_W-1:0] coef_out,
    output logic              x_new,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              commit_pending
);

    state_t     r_state;
    logic [1:0] r_tap;
    logic       r_mac_en;
    logic       r_mac_clr;
    logic       r_mac_src;
    logic       r_wb_en;
    logic       r_out_valid;
    logic       r_x_new;
    logic       r_overrun;
    logic       w_idle;
    logic       w_accept;
    logic       w_commit_pending;

    assign w_idle   = (r_state == ST_IDLE);
    assign in_ready = w_idle & ~w_commit_pending;
    assign busy     = ~in_ready;
    assign w_accept = in_valid & in_ready;

    dlf_coef_bank #(
        .COEF_W (COEF_W),
        .B_W    (B_W)
    ) u_coef_bank (
        .clk            (clk),
        .rst            (rstn),
        .we             (cfg_we),
        .addr           (cfg_addr),
        .data           (cfg_data),
        .commit_req     (cfg_commit),
        .idle           (w_idle),
        .sel_b          (r_state == ST_FF),
        .sel_a          (r_state == ST_FB),
        .tap            (r_tap),
        .commit_pending (w_commit_pending),
        .coef           (coef_out)
    );

    // Frame sequencer with registered strobes and sticky overrun
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= ST_IDLE;
            r_tap       <= 2'd0;
            r_mac_en    <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_src   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_x_new     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mac_clr   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_FF;
                        r_tap     <= 2'd0;
                        r_mac_en  <= 1'b1;
                        r_mac_clr <= 1'b1;
                        r_mac_src <= 1'b0;
                        r_x_new   <= in_data;
                    end
                end
                ST_FF: begin
                    if (r_tap == 2'd3) begin
                        r_state   <= ST_FB;
                        r_tap     <= 2'd0;
                        r_mac_src <= 1'b1;
                    end else begin
                        r_tap <= r_tap + 2'd1;
                    end
                end
                ST_FB: begin
                    if (r_tap == 2'd3) begin
                        r_state     <= ST_WB;
                        r_tap       <= 2'd0;
                        r_mac_en    <= 1'b0;
                        r_mac_src   <= 1'b0;
                        r_wb_en     <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_tap <= r_tap + 2'd1;
                    end
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // A strobe that cannot be taken outranks a same-cycle clear
            if (in_valid && !in_ready) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign mac_en         = r_mac_en;
    assign mac_clr        = r_mac_clr;
    assign mac_src        = r_mac_src;
    assign wb_en          = r_wb_en;
    assign out_valid      = r_out_valid;
    assign tap_idx        = r_tap;
    assign x_new          = r_x_new;
    assign overrun        = r_overrun;
    assign commit_pending = w_commit_pending;

endmodule
`default_nettype wire

// File: tb/tb_dlf_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlf_mac_sequencer
// Description : Scoreboard bench for dlf_mac_sequencer. A cycle-level
//               reference model predicts handshake/status outputs and queues
//               the expected MAC tap and write-back events; a monitor pops
//               and compares them as the DUT emits them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dlf_mac_sequencer;

    localparam int COEF_W = 21;
    localparam int B_W    = 13;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_data;
    logic              in_ready;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_commit;
    logic              ovr_clr;
    logic              mac_clr;
    logic              mac_en;
    logic              mac_src;
    logic              wb_en;
    logic [1:0]        tap_idx;
    logic [COEF_W-1:0] coef_out;
    logic              x_new;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic              commit_pending;

    always #5 clk = ~clk;

    dlf_mac_sequencer #(.COEF_W(COEF_W), .B_W(B_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .ovr_clr        (ovr_clr),
        .mac_clr        (mac_clr),
        .mac_en         (mac_en),
        .mac_src        (mac_src),
        .wb_en          (wb_en),
        .tap_idx        (tap_idx),
        .coef_out       (coef_out),
        .x_new          (x_new),
        .out_valid      (out_valid),
        .busy           (busy),
        .overrun        (overrun),
        .commit_pending (commit_pending)
    );

    typedef struct {
        int          cyc;
        logic        src;
        logic [1:0]  tap;
        logic [20:0] coef;
        logic        clr;
    } tap_t;

    typedef struct {
        int   cyc;
        logic x;
    } wb_t;

    tap_t tq[$];
    wb_t  wq[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [12:0] m_b_sh  [4];
    logic [12:0] m_b_act [4];
    logic [20:0] m_a_sh  [4];
    logic [20:0] m_a_act [4];
    int          busy_until;
    logic        m_pend;
    logic        m_ovr;
    logic        m_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_b_sh[0] = 13'h0B66; m_b_sh[1] = 13'h0BD7; m_b_sh[2] = 13'h157A; m_b_sh[3] = 13'h150A;
        m_a_sh[0] = 21'h091DFC; m_a_sh[1] = 21'h110794; m_a_sh[2] = 21'h066CEC; m_a_sh[3] = 21'h1F6D98;
        for (int k = 0; k < 4; k++) begin
            m_b_act[k] = m_b_sh[k];
            m_a_act[k] = m_a_sh[k];
        end
        busy_until = -1;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_x    = 1'b0;
    endtask

    // One clock cycle: check status outputs, drive inputs, advance the model
    task automatic step(input logic v, input logic d, input logic we, input logic [2:0] a,
                        input logic [20:0] dat, input logic cm, input logic clr, input logic rs);
        logic rdy;
        logic dc;
        tap_t t;
        wb_t  w;
        @(negedge clk);
        #1;
        rdy = (cyc > busy_until) && !m_pend;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("busy", 32'(busy), 32'(!rdy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        chk("x_new", 32'(x_new), 32'(m_x));
        in_valid   = v;
        in_data    = d;
        cfg_we     = we;
        cfg_addr   = a;
        cfg_data   = dat;
        cfg_commit = cm;
        ovr_clr    = clr;
        rstn       = rs;
        if (rs) begin
            model_reset();
            tq.delete();
            wq.delete();
        end else begin
            dc = (cyc > busy_until) && m_pend;
            if (we) begin
                if (a[2]) m_a_sh[a[1:0]] = dat;
                else      m_b_sh[a[1:0]] = dat[12:0];
            end
            if (dc) begin
                for (int k = 0; k < 4; k++) begin
                    m_b_act[k] = m_b_sh[k];
                    m_a_act[k] = m_a_sh[k];
                end
            end
            if (v && rdy) begin
                for (int k = 0; k < 4; k++) begin
                    t.cyc = cyc + 1 + k; t.src = 1'b0; t.tap = 2'(k);
                    t.coef = 21'($signed(m_b_act[k])); t.clr = (k == 0);
                    tq.push_back(t);
                end
                for (int k = 0; k < 4; k++) begin
                    t.cyc = cyc + 5 + k; t.src = 1'b1; t.tap = 2'(k);
                    t.coef = m_a_act[k]; t.clr = 1'b0;
                    tq.push_back(t);
                end
                w.cyc = cyc + 9;
                w.x   = d;
                wq.push_back(w);
                busy_until = cyc + 9;
                m_x = d;
            end
            if (v && !rdy)  m_ovr = 1'b1;
            else if (clr)   m_ovr = 1'b0;
            m_pend = cm || (m_pend && !dc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input logic d);
        step(1'b1, d, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops expected events whenever the DUT strobes
    always @(negedge clk) begin : mon
        tap_t e;
        wb_t  w;
        if (mon_on) begin
            while (tq.size() > 0 && tq[0].cyc < cyc) begin
                chk("tap_missing_cycle", 32'(cyc), 32'(tq[0].cyc));
                void'(tq.pop_front());
            end
            if (mac_en === 1'b1) begin
                if (tq.size() == 0) begin
                    chk("unexpected_mac_en", 32'(mac_en), 32'd0);
                end else begin
                    e = tq.pop_front();
                    chk("mac_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mac_src", 32'(mac_src), 32'(e.src));
                    chk("tap_idx", 32'(tap_idx), 32'(e.tap));
                    chk("coef_out", 32'(coef_out), 32'(e.coef));
                    chk("mac_clr", 32'(mac_clr), 32'(e.clr));
                end
            end else begin
                chk("mac_clr_idle", 32'(mac_clr), 32'd0);
                chk("coef_out_idle", 32'(coef_out), 32'd0);
            end
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk("wb_missing_cycle", 32'(cyc), 32'(wq[0].cyc));
                void'(wq.pop_front());
            end
            chk("wb_en_eq_out_valid", 32'(wb_en), 32'(out_valid));
            if (out_valid === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("wb_cycle", 32'(cyc), 32'(w.cyc));
                    chk("wb_x_new", 32'(x_new), 32'(w.x));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; in_data = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        cfg_commit = 0; ovr_clr = 0; rstn = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        mon_on = 1'b1;
        idle(3);

        // Single frame with reset coefficients
        strobe(1'b1);
        idle(12);

        // Overrun at T+4, clear at T+5, next strobe at T+10
        strobe(1'b0);
        idle(3);
        strobe(1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b1, 1'b0);
        idle(4);
        strobe(1'b1);
        idle(12);

        // Shadow write + commit mid-frame; applied only once idle
        strobe(1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 3'd4, 21'h012345, 1'b1, 1'b0, 1'b0);
        idle(7);
        idle(1);
        strobe(1'b0);
        idle(12);

        // Reset mid-frame at T+6
        strobe(1'b1);
        idle(5);
        step(1'b0, 1'b0, 1'b0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        strobe(1'b1);
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
                 3'($urandom), 21'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0);
        end

        idle(14);
        chk("tap_queue_drained", 32'(tq.size()), 32'd0);
        chk("wb_queue_drained", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
